// File: rtl/alu_sequencer_if.sv
// Handshake and ALU-facing signal bundle for the ALU sequencer.
// The sequencer connects through the slave modport. The request source,
// response consumer and ALU connect through the master modport.
interface alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] YMuxOut;
   logic [31:0] BusMuxOut;
   logic [4:0]  ALUControl;
   logic [63:0] ZMuxIn;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_lo;
   logic [31:0] rsp_hi;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b, ZMuxIn, rsp_ready,
      output req_ready, YMuxOut, BusMuxOut, ALUControl,
             rsp_valid, rsp_lo, rsp_hi, rsp_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b, ZMuxIn, rsp_ready,
      input  req_ready, YMuxOut, BusMuxOut, ALUControl,
             rsp_valid, rsp_lo, rsp_hi, rsp_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: takes one opcode plus two operands, presents the operands
// to the ALU, holds ALUControl for a fixed number of cycles, captures the
// 64-bit Z result and returns it over a valid/ready response handshake.
// Every output comes straight from a register, so no request or response
// input reaches an output in the same cycle.
module alu_sequencer #(
   parameter int unsigned EXEC_CYCLES   = 1,
   parameter int unsigned MULDIV_CYCLES = 4
) (
   input logic            clock,
   input logic            clear,
   alu_sequencer_if.slave bus
);

   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   localparam logic [3:0] EXEC_COUNT   = 4'(EXEC_CYCLES);
   localparam logic [3:0] MULDIV_COUNT = 4'(MULDIV_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_Y,
      EXEC,
      CAPTURE,
      RESP
   } seqState;

   seqState     state;
   logic [4:0]  opReg;
   logic [3:0]  cycleCount;
   logic [31:0] yReg;
   logic [31:0] busReg;
   logic [63:0] zReg;
   logic        errReg;
   logic        reqReadyReg;
   logic        rspValidReg;
   logic [4:0]  aluControlReg;

   logic        reqFire;
   logic        reqReject;

   // Opcodes the ALU implements; anything else is answered with an error.
   function automatic logic isLegal(input logic [4:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01000, 5'b01001, 5'b01010, 5'b01011,
         5'b01111, 5'b10000, 5'b10001, 5'b10010: legal = 1'b1;
         default:                                 legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic isMulDiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // Request handshake and early rejection, evaluated on the live request.
   assign reqFire   = bus.req_valid && reqReadyReg;
   assign reqReject = !isLegal(bus.req_op) ||
                      ((bus.req_op == OP_DIV) && (bus.req_b == 32'd0));

   // Sequencer FSM; every output is a register written on state transitions.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; where two assignments to the same register
   // fire in one branch, the later one wins.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state         <= IDLE;
         opReg         <= OP_NOP;
         cycleCount    <= 4'd0;
         yReg          <= 32'd0;
         busReg        <= 32'd0;
         zReg          <= 64'd0;
         errReg        <= 1'b0;
         reqReadyReg   <= 1'b0;
         rspValidReg   <= 1'b0;
         aluControlReg <= OP_NOP;
      end else begin
         case (state)
            IDLE: begin
               // req_ready comes back one cycle after reset is released.
               reqReadyReg <= 1'b1;
               if (reqFire) begin
                  reqReadyReg <= 1'b0;
                  opReg       <= bus.req_op;
                  if (reqReject) begin
                     zReg        <= 64'd0;
                     errReg      <= 1'b1;
                     rspValidReg <= 1'b1;
                     state       <= RESP;
                  end else begin
                     errReg <= 1'b0;
                     yReg   <= bus.req_a;
                     busReg <= bus.req_b;
                     state  <= LOAD_Y;
                  end
               end
            end

            LOAD_Y: begin
               // Operands are already on the ALU inputs; the opcode follows.
               cycleCount    <= isMulDiv(opReg) ? MULDIV_COUNT : EXEC_COUNT;
               aluControlReg <= opReg;
               state         <= EXEC;
            end

            EXEC: begin
               if (cycleCount <= 4'd1) begin
                  state <= CAPTURE;
               end else begin
                  cycleCount <= cycleCount - 4'd1;
               end
            end

            CAPTURE: begin
               zReg          <= bus.ZMuxIn;
               aluControlReg <= OP_NOP;
               rspValidReg   <= 1'b1;
               state         <= RESP;
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  rspValidReg <= 1'b0;
                  reqReadyReg <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               state         <= IDLE;
               aluControlReg <= OP_NOP;
               rspValidReg   <= 1'b0;
               reqReadyReg   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = reqReadyReg;
   assign bus.YMuxOut    = yReg;
   assign bus.BusMuxOut  = busReg;
   assign bus.ALUControl = aluControlReg;
   assign bus.rsp_valid  = rspValidReg;
   assign bus.rsp_lo     = zReg[31:0];
   assign bus.rsp_hi     = zReg[63:32];
   assign bus.rsp_err    = errReg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer. Two instances share stimulus: one
// with default cycle counts, one with EXEC_CYCLES=3 / MULDIV_CYCLES=1.
// A behavioural ALU closes the ZMuxIn loop; expected results are constants.
module tb_alu_sequencer;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expLo;
      logic [31:0] expHi;
      logic        expErr;
      int          expLat;   // edges from the accepting edge to rsp_valid
      int          expAlu;   // cycles ALUControl is non-zero
      int          hold;     // cycles rsp_ready is held low in RESP
   } vecT;

   logic clock;
   logic clear;

   logic        req_valid;
   logic [4:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_ready;

   int checks;
   int errors;
   int edgeCount;
   bit sel;

   alu_sequencer_if bus0 ();
   alu_sequencer_if bus1 ();

   alu_sequencer dut0 (
      .clock (clock),
      .clear (clear),
      .bus   (bus0)
   );

   alu_sequencer #(
      .EXEC_CYCLES   (3),
      .MULDIV_CYCLES (1)
   ) dut1 (
      .clock (clock),
      .clear (clear),
      .bus   (bus1)
   );

   // Behavioural ALU: 32-bit results in the low word, mul gives 64 bits,
   // div gives quotient low / remainder high, neg and not act on B.
   function automatic logic [63:0] aluModel(input logic [4:0] op,
                                            input logic [31:0] y,
                                            input logic [31:0] b);
      logic [63:0] r;
      r = 64'd0;
      case (op)
         5'b00011: r[31:0] = y + b;
         5'b00100: r[31:0] = y - b;
         5'b00101: r[31:0] = y & b;
         5'b00110: r[31:0] = y | b;
         5'b00111: r[31:0] = y >> b[4:0];
         5'b01000: r[31:0] = $signed(y) >>> b[4:0];
         5'b01001: r[31:0] = y << b[4:0];
         5'b01010: r[31:0] = (y >> b[4:0]) | (y << (6'd32 - {1'b0, b[4:0]}));
         5'b01011: r[31:0] = (y << b[4:0]) | (y >> (6'd32 - {1'b0, b[4:0]}));
         5'b01111: r = {32'd0, y} * {32'd0, b};
         5'b10000: if (b != 32'd0) r = {y % b, y / b};
         5'b10001: r[31:0] = -b;
         5'b10010: r[31:0] = ~b;
         default:  r = 64'd0;
      endcase
      return r;
   endfunction

   assign bus0.req_valid = req_valid;
   assign bus0.req_op    = req_op;
   assign bus0.req_a     = req_a;
   assign bus0.req_b     = req_b;
   assign bus0.rsp_ready = rsp_ready;
   assign bus0.ZMuxIn    = aluModel(bus0.ALUControl, bus0.YMuxOut, bus0.BusMuxOut);

   assign bus1.req_valid = req_valid;
   assign bus1.req_op    = req_op;
   assign bus1.req_a     = req_a;
   assign bus1.req_b     = req_b;
   assign bus1.rsp_ready = rsp_ready;
   assign bus1.ZMuxIn    = aluModel(bus1.ALUControl, bus1.YMuxOut, bus1.BusMuxOut);

   // Observed outputs of whichever instance is under test.
   logic        sReqReady;
   logic        sRspValid;
   logic        sRspErr;
   logic [4:0]  sAluControl;
   logic [31:0] sRspLo;
   logic [31:0] sRspHi;
   logic [31:0] sYMux;
   logic [31:0] sBusMux;

   assign sReqReady   = sel ? bus1.req_ready  : bus0.req_ready;
   assign sRspValid   = sel ? bus1.rsp_valid  : bus0.rsp_valid;
   assign sRspErr     = sel ? bus1.rsp_err    : bus0.rsp_err;
   assign sAluControl = sel ? bus1.ALUControl : bus0.ALUControl;
   assign sRspLo      = sel ? bus1.rsp_lo     : bus0.rsp_lo;
   assign sRspHi      = sel ? bus1.rsp_hi     : bus0.rsp_hi;
   assign sYMux       = sel ? bus1.YMuxOut    : bus0.YMuxOut;
   assign sBusMux     = sel ? bus1.BusMuxOut  : bus0.BusMuxOut;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) edgeCount <= edgeCount + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge with the DUT idle; returns at a falling edge
   // with the DUT idle again, so consecutive calls issue back-to-back.
   task automatic runVec(input vecT v, output int accEdge);
      int d;
      int aluCnt;
      int aluBad;
      check("req_ready before request", sReqReady, 1);
      rsp_ready = (v.hold == 0);
      req_valid = 1'b1;
      req_op    = v.op;
      req_a     = v.a;
      req_b     = v.b;
      @(negedge clock);
      accEdge   = edgeCount;
      req_valid = 1'b0;
      d = 0;
      aluCnt = 0;
      aluBad = 0;
      while (!sRspValid && d < 40) begin
         if (sAluControl != 5'd0) begin
            aluCnt++;
            if (sAluControl != v.op) aluBad++;
         end
         if (sReqReady) aluBad++;
         @(negedge clock);
         d++;
      end
      check("response latency", d, v.expLat);
      check("ALUControl active cycles", aluCnt, v.expAlu);
      check("ALUControl value / busy req_ready", aluBad, 0);
      check("rsp_lo", sRspLo, v.expLo);
      check("rsp_hi", sRspHi, v.expHi);
      check("rsp_err", sRspErr, v.expErr);
      check("ALUControl in RESP", sAluControl, 0);
      check("req_ready in RESP", sReqReady, 0);
      if (!v.expErr) begin
         check("YMuxOut held", sYMux, v.a);
         check("BusMuxOut held", sBusMux, v.b);
      end
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clock);
         check("held rsp_valid", sRspValid, 1);
         check("held rsp_lo/hi", {sRspHi, sRspLo}, {v.expHi, v.expLo});
         check("held rsp_err", sRspErr, v.expErr);
         check("held req_ready", sReqReady, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      check("rsp_valid after handshake", sRspValid, 0);
      check("req_ready back in IDLE", sReqReady, 1);
   endtask

   vecT vecs [12];
   vecT sweep [2];
   int  acc [12];
   int  accSweep [2];
   int  seenRsp;

   initial begin
      vecs[0]  = '{5'b00011, 32'd5,          32'd7,          32'd12,         32'd0, 1'b0, 3, 2, 0};
      vecs[1]  = '{5'b01111, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd1, 1'b0, 6, 5, 5};
      vecs[2]  = '{5'b10000, 32'd100,        32'd0,          32'd0,          32'd0, 1'b1, 0, 0, 0};
      vecs[3]  = '{5'b11111, 32'd9,          32'd4,          32'd0,          32'd0, 1'b1, 0, 0, 0};
      vecs[4]  = '{5'b00100, 32'd10,         32'd3,          32'd7,          32'd0, 1'b0, 3, 2, 0};
      vecs[5]  = '{5'b10010, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0, 1'b0, 3, 2, 0};
      vecs[6]  = '{5'b00101, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  32'd0, 1'b0, 3, 2, 0};
      vecs[7]  = '{5'b01010, 32'd1,          32'd1,          32'h8000_0000,  32'd0, 1'b0, 3, 2, 0};
      vecs[8]  = '{5'b10000, 32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 6, 5, 0};
      vecs[9]  = '{5'b00100, 32'd0,          32'd1,          32'hFFFF_FFFF,  32'd0, 1'b0, 3, 2, 0};
      vecs[10] = '{5'b00000, 32'd3,          32'd3,          32'd0,          32'd0, 1'b1, 0, 0, 0};
      vecs[11] = '{5'b01000, 32'h8000_0000,  32'd4,          32'hF800_0000,  32'd0, 1'b0, 3, 2, 0};
      sweep[0] = '{5'b00011, 32'd20,         32'd22,         32'd42,         32'd0, 1'b0, 5, 4, 0};
      sweep[1] = '{5'b01111, 32'd3,          32'd5,          32'd15,         32'd0, 1'b0, 3, 2, 0};

      checks    = 0;
      errors    = 0;
      edgeCount = 0;
      sel       = 1'b0;
      clear     = 1'b1;
      req_valid = 1'b0;
      req_op    = 5'd0;
      req_a     = 32'd0;
      req_b     = 32'd0;
      rsp_ready = 1'b1;

      // Reset state.
      @(negedge clock);
      check("reset req_ready", sReqReady, 0);
      check("reset rsp_valid", sRspValid, 0);
      check("reset ALUControl", sAluControl, 0);
      check("reset Y/Bus", {sYMux, sBusMux}, 64'd0);
      check("reset Z/err", {sRspErr, sRspHi, sRspLo}, 65'd0);
      clear = 1'b0;
      @(negedge clock);
      check("req_ready after release", sReqReady, 1);

      // Default-parameter instance, table driven.
      for (int i = 0; i < 12; i++) runVec(vecs[i], acc[i]);
      // Accept, LOAD_Y, EXEC, CAPTURE, RESP, IDLE, next accept: 5 edges.
      check("back-to-back accept spacing", acc[5] - acc[4], 5);

      // Reset during EXEC of a multiply.
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op    = 5'b01111;
      req_a     = 32'd6;
      req_b     = 32'd7;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check("mul in EXEC before clear", sAluControl, 5'b01111);
      #2 clear = 1'b1;
      #1;
      check("clear ALUControl", sAluControl, 0);
      check("clear rsp_valid", sRspValid, 0);
      check("clear req_ready", sReqReady, 0);
      @(negedge clock);
      check("clear held req_ready", sReqReady, 0);
      clear = 1'b0;
      @(negedge clock);
      check("req_ready one cycle after release", sReqReady, 1);
      seenRsp = 0;
      for (int i = 0; i < 8; i++) begin
         if (sRspValid || sAluControl != 5'd0) seenRsp++;
         @(negedge clock);
      end
      check("no response from discarded op", seenRsp, 0);

      // Non-default cycle counts.
      sel = 1'b1;
      check("sweep instance idle", sReqReady, 1);
      for (int i = 0; i < 2; i++) runVec(sweep[i], accSweep[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
